// File: rtl/instr_loader.sv
// Boot-time instruction loader: receives a length byte plus little-endian words over a byte
// stream, writes them to instruction memory, and stalls the CPU (feeding it NOPs) while busy.
module instr_loader #(
  parameter int DEPTH   = 64,
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 50000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  input  logic [31:0]         cpu_rAddr,
  output logic [31:0]         instr_code,
  output logic                cpu_stall,
  output logic [ADDR_W-1:0]   mem_rAddr,
  input  logic [31:0]         mem_rData,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_wAddr,
  output logic [31:0]         mem_wData,
  output logic                load_done,
  output logic                err,
  output logic [ADDR_W:0]     word_count
);

  localparam int          TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, GET_LEN, GET_WORD, DONE} state_t;

  state_t            state;
  logic [ADDR_W:0]   len_m1;
  logic [1:0]        byte_idx;
  logic [23:0]       asm_word;
  logic [TO_W-1:0]   idle_cnt;
  logic              len_ok;
  logic              unused_addr_bits;

  assign mem_rAddr        = cpu_rAddr[ADDR_W+1:2];
  assign instr_code       = (state == IDLE) ? mem_rData : NOP;
  assign cpu_stall        = (state != IDLE);
  assign len_ok           = (rx_data != 8'd0) && ({24'd0, rx_data} <= DEPTH_U);
  assign unused_addr_bits = ^{cpu_rAddr[31:ADDR_W+2], cpu_rAddr[1:0]};

  // Only three bytes are buffered; the fourth goes straight into the completion register,
  // which frees the assembly register for the next word's byte 0 one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      len_m1     <= '0;
      byte_idx   <= '0;
      asm_word   <= '0;
      idle_cnt   <= '0;
      mem_we     <= 1'b0;
      mem_wAddr  <= '0;
      mem_wData  <= '0;
      load_done  <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
    end else begin
      mem_we    <= 1'b0;
      load_done <= 1'b0;
      if (mem_we) begin
        mem_wAddr  <= mem_wAddr + 1'b1;
        word_count <= word_count + 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state      <= GET_LEN;
            err        <= 1'b0;
            word_count <= '0;
            byte_idx   <= '0;
            mem_wAddr  <= '0;
            idle_cnt   <= '0;
          end
        end
        GET_LEN: begin
          if (rx_valid) begin
            idle_cnt <= '0;
            if (len_ok) begin
              len_m1 <= (ADDR_W+1)'(rx_data - 8'd1);
              state  <= GET_WORD;
            end else begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end else if (idle_cnt == TO_LAST) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        GET_WORD: begin
          if (rx_valid) begin
            idle_cnt <= '0;
            byte_idx <= byte_idx + 1'b1;
            case (byte_idx)
              2'd0: asm_word[7:0]   <= rx_data;
              2'd1: asm_word[15:8]  <= rx_data;
              2'd2: asm_word[23:16] <= rx_data;
              default: begin
                mem_we    <= 1'b1;
                mem_wData <= {rx_data, asm_word};
                // word_count always equals the index of the word being completed here
                if (word_count == len_m1) begin
                  state     <= DONE;
                  load_done <= 1'b1;
                end
              end
            endcase
          end else if (idle_cnt == TO_LAST) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: a byte-list model predicts the writes, error and word count;
// a per-cycle compare process checks the fetch path and every memory write against it.
module tb_instr_loader;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [5:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset, start, rx_valid;
  logic [7:0]  rx_data;
  logic [31:0] cpu_rAddr, instr_code, mem_rData, mem_wData;
  logic        cpu_stall, mem_we, load_done, err;
  logic [5:0]  mem_rAddr, mem_wAddr;
  logic [6:0]  word_count;

  logic [31:0] bmem [64];
  wr_t         exp_q[$];
  int          ncmp = 0, nerr = 0;
  int          done_cnt = 0;
  int          exp_wc, exp_done;
  logic        exp_err;
  logic        chk_on = 1'b0;
  logic        prev_done = 1'b0;

  instr_loader #(.DEPTH(64), .ADDR_W(6), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .cpu_rAddr(cpu_rAddr), .instr_code(instr_code), .cpu_stall(cpu_stall),
    .mem_rAddr(mem_rAddr), .mem_rData(mem_rData), .mem_we(mem_we), .mem_wAddr(mem_wAddr),
    .mem_wData(mem_wData), .load_done(load_done), .err(err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) bmem[mem_wAddr] <= mem_wData;
  assign mem_rData = bmem[mem_rAddr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outcome of a load, computed straight from the byte list.
  task automatic plan(input bq_t b);
    int L, nw;
    wr_t w;
    exp_q.delete();
    L = b[0];
    if (L == 0 || L > 64) begin
      exp_err = 1'b1; exp_wc = 0; exp_done = 0;
    end else begin
      nw = (b.size() - 1) / 4;
      if (nw >= L) begin
        nw = L; exp_done = 1; exp_err = 1'b0;
      end else begin
        exp_done = 0; exp_err = 1'b1;
      end
      for (int k = 0; k < nw; k++) begin
        w.a = 6'(k);
        w.d = {b[4*k+4], b[4*k+3], b[4*k+2], b[4*k+1]};
        exp_q.push_back(w);
      end
      exp_wc = nw;
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_done = 1'b0;
    end else if (chk_on) begin
      wr_t e;
      check("mem_rAddr", {26'd0, mem_rAddr}, {26'd0, cpu_rAddr[7:2]});
      check("instr_code", instr_code, cpu_stall ? NOP : bmem[cpu_rAddr[7:2]]);
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_we", {31'd0, mem_we}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("mem_wAddr", {26'd0, mem_wAddr}, {26'd0, e.a});
          check("mem_wData", mem_wData, e.d);
        end
      end
      if (load_done) begin
        done_cnt++;
        check("done_with_we", {31'd0, mem_we}, 32'd1);
        check("done_on_last", exp_q.size(), 32'd0);
      end
      if (prev_done) check("stall_after_done", {31'd0, cpu_stall}, 32'd0);
      prev_done = load_done;
    end
  end

  task automatic step(input logic st, input logic v, input logic [7:0] d);
    @(posedge clk);
    #1;
    start = st; rx_valid = v; rx_data = d;
    cpu_rAddr = cpu_rAddr + 32'd4;
  endtask

  task automatic do_start();
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    check("start_err_clr", {31'd0, err}, 32'd0);
    check("start_wc_clr", {25'd0, word_count}, 32'd0);
    check("start_stall", {31'd0, cpu_stall}, 32'd1);
  endtask

  task automatic finish_wait(input string tag);
    int n = 0;
    while (cpu_stall && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_stall_release"}, {31'd0, cpu_stall}, 32'd0);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    check({tag, "_word_count"}, {25'd0, word_count}, 32'(exp_wc));
    check({tag, "_done_pulses"}, done_cnt, exp_done);
    check({tag, "_writes_left"}, exp_q.size(), 32'd0);
  endtask

  task automatic run_load(input string tag, input bq_t b, input int gap, input bit mid_start);
    plan(b);
    done_cnt = 0;
    do_start();
    for (int i = 0; i < b.size(); i++) begin
      step(1'b0, 1'b1, b[i]);
      if (mid_start && i == 2) begin
        step(1'b1, 1'b0, 8'h00);
        @(negedge clk);
        check("nop_in_load", instr_code, NOP);
        check("stall_in_load", {31'd0, cpu_stall}, 32'd1);
      end
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 8'h00);
    end
    step(1'b0, 1'b0, 8'h00);
    finish_wait(tag);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) bmem[i] = 32'hA500_0000 | (i * 32'h0001_0101);
    bmem[17] = 32'hDEAD_BEEF;
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; cpu_rAddr = 32'h0;
    #3;
    check("rst_stall", {31'd0, cpu_stall}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_wAddr", {26'd0, mem_wAddr}, 32'd0);
    check("rst_wData", mem_wData, 32'd0);
    check("rst_done", {31'd0, load_done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_wc", {25'd0, word_count}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    chk_on = 1'b1;

    run_load("two_words", '{8'h02, 8'hB3, 8'h80, 8'h20, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00}, 1, 1'b0);
    check("mem0_literal", bmem[0], 32'h0020_80B3);
    check("mem1_literal", bmem[1], 32'h0000_0013);
    check("wc_literal", {25'd0, word_count}, 32'd2);

    run_load("len_zero", '{8'h00}, 0, 1'b0);
    check("len_zero_err_literal", {31'd0, err}, 32'd1);
    run_load("len_65", '{8'h41}, 0, 1'b0);

    // Timeout: length 1, two data bytes, then silence.
    plan('{8'h01, 8'h13, 8'h05});
    done_cnt = 0;
    do_start();
    step(1'b0, 1'b1, 8'h01);
    step(1'b0, 1'b1, 8'h13);
    step(1'b0, 1'b1, 8'h05);
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 1'b0, 8'h00);
      @(negedge clk);
      check($sformatf("tmo_wait%0d_err", k), {31'd0, err}, 32'd0);
      check($sformatf("tmo_wait%0d_stall", k), {31'd0, cpu_stall}, 32'd1);
    end
    step(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    check("tmo_err", {31'd0, err}, 32'd1);
    check("tmo_stall", {31'd0, cpu_stall}, 32'd0);
    finish_wait("timeout");

    run_load("full_rate", '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88}, 0, 1'b0);
    check("fr_mem0_literal", bmem[0], 32'h4433_2211);
    check("fr_mem1_literal", bmem[1], 32'h8877_6655);

    step(1'b0, 1'b0, 8'h00);
    cpu_rAddr = 32'h44;
    #2;
    check("fetch_rAddr_literal", {26'd0, mem_rAddr}, 32'd17);
    check("fetch_instr_literal", instr_code, 32'hDEAD_BEEF);
    run_load("mid_start", '{8'h01, 8'h13, 8'h05, 8'h00, 8'h00}, 1, 1'b1);
    check("ms_mem0_literal", bmem[0], 32'h0000_0513);

    // Reset after one word and three bytes of the second.
    plan('{8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07});
    do_start();
    step(1'b0, 1'b1, 8'h02);
    for (int i = 1; i <= 7; i++) step(1'b0, 1'b1, 8'(i));
    step(1'b0, 1'b0, 8'h00);
    check("pre_rst_w0_written", exp_q.size(), 32'd0);
    check("pre_rst_wc", {25'd0, word_count}, 32'd1);
    check("pre_rst_wAddr", {26'd0, mem_wAddr}, 32'd1);
    check("pre_rst_wData", mem_wData, 32'h0403_0201);
    reset = 1'b1;
    #2;
    check("mid_rst_stall", {31'd0, cpu_stall}, 32'd0);
    check("mid_rst_we", {31'd0, mem_we}, 32'd0);
    check("mid_rst_wAddr", {26'd0, mem_wAddr}, 32'd0);
    check("mid_rst_wData", mem_wData, 32'd0);
    check("mid_rst_done", {31'd0, load_done}, 32'd0);
    check("mid_rst_err", {31'd0, err}, 32'd0);
    check("mid_rst_wc", {25'd0, word_count}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'hFF);
    step(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    check("post_rst_stall", {31'd0, cpu_stall}, 32'd0);
    check("post_rst_wc", {25'd0, word_count}, 32'd0);
    check("post_rst_err", {31'd0, err}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
